// File: rtl/addr_seq_ctrl_if.sv
// Job-request and address-beat bus for addr_seq_ctrl.
// The slave modport is the sequencer's view; the master modport is the requester/sink view.
interface addr_seq_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REQ    = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_start;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_end;
    logic                          addr_valid;
    logic                          addr_ready;
    logic [ADDR_WIDTH-1:0]         addr;
    logic                          addr_last;
    logic                          addr_src;
    logic                          done;
    logic                          done_src;

    modport master (
        output req_valid, req_start, req_end, addr_ready,
        input  req_ready, addr_valid, addr, addr_last, addr_src, done, done_src
    );

    modport slave (
        input  req_valid, req_start, req_end, addr_ready,
        output req_ready, addr_valid, addr, addr_last, addr_src, done, done_src
    );
endinterface

// File: rtl/addr_seq_ctrl.sv
// Two-requester round-robin address sequencer: grants one job at a time and
// streams start..end (wrapping modulo 2^ADDR_WIDTH) as valid/ready beats.
module addr_seq_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REQ    = 2
) (
    input logic          clk,
    input logic          rst_n,
    addr_seq_ctrl_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   cnt, end_q;
    logic                    id_q, last_q, done_q, done_src_q;
    logic                    gnt_id, hs, beat, at_end;
    logic                    addr_valid_c, addr_last_c;
    logic [NUM_REQ-1:0]      req_ready_c;
    logic [ADDR_WIDTH-1:0]   start_sel, end_sel;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx     = state;
        req_ready_c  = '0;
        addr_valid_c = 1'b0;
        addr_last_c  = 1'b0;
        hs           = 1'b0;
        beat         = 1'b0;
        at_end       = (cnt == end_q);
        // Round-robin: on contention the requester not granted last time wins.
        case (bus.req_valid)
            2'b01:   gnt_id = 1'b0;
            2'b10:   gnt_id = 1'b1;
            2'b11:   gnt_id = ~last_q;
            default: gnt_id = 1'b0;
        endcase
        case (state)
            IDLE: begin
                if ((|bus.req_valid) && !rst_n) begin
                    req_ready_c[gnt_id] = 1'b1;
                    hs                  = 1'b1;
                    state_nx            = RUN;
                end
            end
            RUN: begin
                addr_valid_c = 1'b1;
                addr_last_c  = at_end;
                beat         = bus.addr_ready;
                if (beat && at_end) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign start_sel = gnt_id ? bus.req_start[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.req_start[ADDR_WIDTH-1:0];
    assign end_sel   = gnt_id ? bus.req_end[2*ADDR_WIDTH-1:ADDR_WIDTH]   : bus.req_end[ADDR_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt        <= '0;
            end_q      <= '0;
            id_q       <= 1'b0;
            last_q     <= 1'b1;
            done_q     <= 1'b0;
            done_src_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (hs) begin
                cnt    <= start_sel;
                end_q  <= end_sel;
                id_q   <= gnt_id;
                last_q <= gnt_id;
            end else if (beat) begin
                if (at_end) begin
                    done_q     <= 1'b1;
                    done_src_q <= id_q;
                end else begin
                    cnt <= cnt + ADDR_WIDTH'(1);
                end
            end
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.addr_valid = addr_valid_c;
    assign bus.addr       = cnt;
    assign bus.addr_last  = addr_last_c;
    assign bus.addr_src   = id_q;
    assign bus.done       = done_q;
    assign bus.done_src   = done_src_q;
endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Directed bench for addr_seq_ctrl (ADDR_WIDTH=4): single jobs, wrap, alternating
// grants, backpressure hold, and mid-job asynchronous reset.
module tb_addr_seq_ctrl;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    addr_seq_ctrl_if #(.ADDR_WIDTH(4), .NUM_REQ(2)) bus ();

    addr_seq_ctrl #(.ADDR_WIDTH(4), .NUM_REQ(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic id, input logic [3:0] s, input logic [3:0] e);
        @(negedge clk);
        bus.req_valid = id ? 2'b10 : 2'b01;
        bus.req_start = id ? {s, 4'h0} : {4'h0, s};
        bus.req_end   = id ? {e, 4'h0} : {4'h0, e};
        #1;
        chk("grant", {30'd0, bus.req_ready}, id ? 32'h2 : 32'h1);
        @(posedge clk);
        #1;
        bus.req_valid = 2'b00;
        bus.req_start = 8'($urandom);
        bus.req_end   = 8'($urandom);
    endtask

    task automatic expect_beat(input logic [3:0] a, input logic last, input logic src);
        @(negedge clk);
        chk("beat_valid", {31'd0, bus.addr_valid}, 32'h1);
        chk("beat_addr",  {28'd0, bus.addr}, {28'd0, a});
        chk("beat_last",  {31'd0, bus.addr_last}, {31'd0, last});
        chk("beat_src",   {31'd0, bus.addr_src}, {31'd0, src});
        chk("run_ready",  {30'd0, bus.req_ready}, 32'h0);
    endtask

    task automatic expect_done(input logic src);
        @(negedge clk);
        chk("done",       {31'd0, bus.done}, 32'h1);
        chk("done_src",   {31'd0, bus.done_src}, {31'd0, src});
        chk("idle_valid", {31'd0, bus.addr_valid}, 32'h0);
        @(negedge clk);
        chk("done_pulse", {31'd0, bus.done}, 32'h0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_start = 8'h00;
        bus.req_end   = 8'h00;
        bus.addr_ready = 1'b1;

        // Reset state: ready suppressed even with requests pending
        repeat (2) @(negedge clk);
        chk("rst_ready", {30'd0, bus.req_ready}, 32'h0);
        chk("rst_valid", {31'd0, bus.addr_valid}, 32'h0);
        chk("rst_addr",  {28'd0, bus.addr}, 32'h0);
        chk("rst_done",  {31'd0, bus.done}, 32'h0);
        bus.req_valid = 2'b00;
        rst_n = 1'b0;

        // Requester 0, 3..6
        start_job(1'b0, 4'd3, 4'd6);
        expect_beat(4'd3, 1'b0, 1'b0);
        expect_beat(4'd4, 1'b0, 1'b0);
        expect_beat(4'd5, 1'b0, 1'b0);
        expect_beat(4'd6, 1'b1, 1'b0);
        expect_done(1'b0);

        // Requester 1, wrapping 14..1
        start_job(1'b1, 4'd14, 4'd1);
        expect_beat(4'd14, 1'b0, 1'b1);
        expect_beat(4'd15, 1'b0, 1'b1);
        expect_beat(4'd0,  1'b0, 1'b1);
        expect_beat(4'd1,  1'b1, 1'b1);
        expect_done(1'b1);

        // Both valid continuously, single-beat jobs: grants alternate 0,1,0,1
        @(negedge clk);
        bus.req_valid = 2'b11;
        bus.req_start = 8'h55;
        bus.req_end   = 8'h55;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_grant", {30'd0, bus.req_ready}, (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k > 0) begin
                chk("rr_done",     {31'd0, bus.done}, 32'h1);
                chk("rr_done_src", {31'd0, bus.done_src}, ((k - 1) % 2 == 0) ? 32'h0 : 32'h1);
            end
            @(negedge clk);
            chk("rr_addr", {28'd0, bus.addr}, 32'h5);
            chk("rr_last", {31'd0, bus.addr_last}, 32'h1);
            chk("rr_src",  {31'd0, bus.addr_src}, (k % 2 == 0) ? 32'h0 : 32'h1);
            chk("rr_busy", {30'd0, bus.req_ready}, 32'h0);
            @(negedge clk);
        end
        chk("rr_done",     {31'd0, bus.done}, 32'h1);
        chk("rr_done_src", {31'd0, bus.done_src}, 32'h1);
        bus.req_valid = 2'b00;

        // Backpressure on addr=3 of a 2..4 job
        start_job(1'b0, 4'd2, 4'd4);
        expect_beat(4'd2, 1'b0, 1'b0);
        expect_beat(4'd3, 1'b0, 1'b0);
        bus.addr_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, bus.addr_valid}, 32'h1);
            chk("hold_addr",  {28'd0, bus.addr}, 32'h3);
            chk("hold_last",  {31'd0, bus.addr_last}, 32'h0);
            chk("hold_done",  {31'd0, bus.done}, 32'h0);
        end
        bus.addr_ready = 1'b1;
        expect_beat(4'd4, 1'b1, 1'b0);
        expect_done(1'b0);

        // Asynchronous reset mid-job at addr=9 of 8..12
        start_job(1'b0, 4'd8, 4'd12);
        expect_beat(4'd8, 1'b0, 1'b0);
        expect_beat(4'd9, 1'b0, 1'b0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("arst_valid", {31'd0, bus.addr_valid}, 32'h0);
        chk("arst_addr",  {28'd0, bus.addr}, 32'h0);
        chk("arst_last",  {31'd0, bus.addr_last}, 32'h0);
        chk("arst_src",   {31'd0, bus.addr_src}, 32'h0);
        chk("arst_done",  {31'd0, bus.done}, 32'h0);
        @(negedge clk);
        chk("arst_nodone", {31'd0, bus.done}, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("post_done",  {31'd0, bus.done}, 32'h0);
        chk("post_valid", {31'd0, bus.addr_valid}, 32'h0);

        // Single-beat job after reset
        start_job(1'b0, 4'd0, 4'd0);
        expect_beat(4'd0, 1'b1, 1'b0);
        expect_done(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/addr_seq_ctrl.md
ADDR_SEQ_CTRL -- requirements
Module: addr_seq_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, giving the address width in bits (legal values 2..16).
REQ-002 The block SHALL have parameter NUM_REQ, default 2, giving the number of requesters (fixed at 2 in this revision).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-high reset (asserted = 1).
REQ-005 req_valid  input  2  per-requester job request; bit i belongs to requester i.
REQ-006 req_ready  output  2  per-requester job accept; a job transfers when req_valid[i] and req_ready[i] are both 1 at a clock edge.
REQ-007 req_start  input  2*ADDR_WIDTH  first address of a job; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-008 req_end  input  2*ADDR_WIDTH  last address of a job; packed the same way as req_start.
REQ-009 addr_valid  output  1  address beat valid.
REQ-010 addr_ready  input  1  downstream accepts the address beat.
REQ-011 addr  output  ADDR_WIDTH  current address.
REQ-012 addr_last  output  1  current beat is the job's final address.
REQ-013 addr_src  output  1  requester id owning the current beat.
REQ-014 done  output  1  one-cycle pulse on job completion.
REQ-015 done_src  output  1  requester id of the completed job; valid only while done = 1.

Function
REQ-016 The block SHALL use a two-state FSM: IDLE and RUN.
REQ-017 In IDLE with any req_valid bit set, the block SHALL assert exactly one req_ready bit (the grant), combinationally; all other req_ready bits SHALL be 0, and in RUN both SHALL be 0.
REQ-018 Arbitration SHALL be round-robin: when both requesters are valid, the requester not granted most recently wins; when only one is valid, it wins.
REQ-019 On a job handshake the block SHALL latch start, end and the requester id, load the counter with start, and enter RUN on the next cycle.
REQ-020 In RUN, addr_valid SHALL be 1, addr SHALL equal the counter, addr_src SHALL equal the latched id, and addr_last SHALL be 1 exactly when counter == latched end.
REQ-021 While addr_valid = 1 and addr_ready = 0, addr, addr_last and addr_src SHALL hold stable.
REQ-022 On a beat transfer with addr_last = 0, the counter SHALL increment by 1 modulo 2^ADDR_WIDTH.
REQ-023 If end < start, the sequence SHALL wrap through 2^ADDR_WIDTH-1 to 0 and continue to end; job length = ((end - start) mod 2^ADDR_WIDTH) + 1 beats.
REQ-024 If start == end, the job SHALL produce exactly one beat, with addr_last = 1.
REQ-025 On a beat transfer with addr_last = 1, the FSM SHALL return to IDLE, and done SHALL be 1 for exactly the following cycle with done_src = latched id.
REQ-026 A new job SHALL be grantable in the same cycle that done is high, giving one bubble cycle between consecutive jobs.
REQ-027 The last-granted pointer SHALL update only on a job handshake.
REQ-028 req_start and req_end SHALL be ignored except at the handshake edge.

Reset
REQ-029 While rst_n = 1, the block SHALL immediately force: state IDLE, req_ready = 0, addr_valid = 0, addr = 0, addr_last = 0, addr_src = 0, done = 0, done_src = 0, counter = 0, and last-granted pointer = 1 (requester 0 wins first).
REQ-030 Reset asserted mid-job SHALL abort the job without a done pulse; after release the block SHALL be in IDLE.

Verification
REQ-031 ADDR_WIDTH=4; requester 0 job start=3, end=6, addr_ready=1 -> addr 3,4,5,6 on consecutive cycles, addr_last only on 6, done=1 with done_src=0 on the next cycle.
REQ-032 Job start=14, end=1 -> addr 14,15,0,1; addr_last on 1; 4 beats.
REQ-033 Both requesters valid continuously with start=end=5 jobs -> grants alternate 0,1,0,1 beginning with 0; addr_src and done_src alternate to match.
REQ-034 Job start=2, end=4 with addr_ready=0 for 3 cycles while addr=3 -> addr holds 3 with addr_valid=1, then 4 follows; no beat lost or duplicated.
REQ-035 rst_n pulsed high while addr=9 of a 8..12 job -> all outputs 0 asynchronously, no done pulse; after release a new requester 0 job start=0, end=0 yields a single beat with addr_last=1.
